// File: rtl/mem_access_stage.sv
// MEM stage of the RV32IM pipeline: req/gnt/rvalid data-bus access, load extraction, store lanes, MEM/WB register.
// Optional feature: define MISALIGN_TRAP_EN to suppress misaligned accesses and flag them at WB.
module mem_access_stage #(
  parameter int XLEN     = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ExeResult_M,
  input  logic [XLEN-1:0] rs2_data_M,
  input  logic [4:0]      rd_M,
  input  logic [XLEN-1:0] pc_current_M,
  input  logic [31:0]     inst_M,
  input  logic [2:0]      StoreType_M,
  input  logic [2:0]      LoadType_M,
  input  logic            RegWrite_M,
  input  logic            MemWrite_M,
  input  logic            MemRead_M,
  input  logic            MemToReg_M,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] rd_data_W,
  output logic [4:0]      rd_W,
  output logic            RegWrite_W,
  output logic [XLEN-1:0] pc_current_W,
  output logic [31:0]     inst_W,
  output logic            misalign_W
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  localparam logic [2:0] LT_B = 3'b000, LT_H = 3'b001, LT_W = 3'b010, LT_BU = 3'b100, LT_HU = 3'b101;
  localparam logic [2:0] ST_B = 3'b000, ST_H = 3'b001, ST_W = 3'b010;

  state_t          state, state_nxt;
  logic [1:0]      off;
  logic            is_wr, is_rd, mis, trap, acc;
  logic            req, stall;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;

  assign off   = ExeResult_M[1:0];
  // A store wins over a load when both are (illegally) asserted.
  assign is_wr = MemWrite_M;
  assign is_rd = MemRead_M & ~MemWrite_M;

  always_comb begin
    mis = 1'b0;
    if (is_wr) begin
      case (StoreType_M)
        ST_H:    mis = off[0];
        ST_W:    mis = (off != 2'b00);
        default: mis = 1'b0;
      endcase
    end else if (is_rd) begin
      case (LoadType_M)
        LT_H, LT_HU: mis = off[0];
        LT_W:        mis = (off != 2'b00);
        default:     mis = 1'b0;
      endcase
    end
  end

  assign trap = mis & TRAP_EN;
  assign acc  = (is_wr | is_rd) & ~trap;

  // Bus fields
  assign dmem_we   = is_wr;
  assign dmem_addr = {ExeResult_M[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = rs2_data_M;
    case (StoreType_M)
      ST_B: begin
        dmem_wdata = {4{rs2_data_M[7:0]}};
        if (is_wr) dmem_be = 4'b0001 << off;
      end
      ST_H: begin
        dmem_wdata = {2{rs2_data_M[15:0]}};
        if (is_wr) dmem_be = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = rs2_data_M;
        if (is_wr) dmem_be = 4'b1111;
      end
    endcase
  end

  // Load extraction
  assign byte_sel = dmem_rdata[{off, 3'b000} +: 8];
  assign half_sel = dmem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (LoadType_M)
      LT_B:    load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LT_BU:   load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      LT_H:    load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      LT_HU:   load_ext = {{(XLEN-16){1'b0}}, half_sel};
      LT_W:    load_ext = dmem_rdata;
      default: load_ext = dmem_rdata;
    endcase
  end

  // Access FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        req = acc;
        if (acc) begin
          if (!dmem_gnt) begin
            state_nxt = REQ;
            stall     = 1'b1;
          end else if (!is_wr) begin
            state_nxt = WAIT_R;
            stall     = 1'b1;
          end
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (is_wr) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_R;
            stall     = 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) state_nxt = IDLE;
        else             stall     = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_req  = req & ~rst;
  assign mem_stall = stall & ~rst;

  // MEM/WB register; a stall cycle turns the WB slot into a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_W    <= '0;
      rd_W         <= '0;
      RegWrite_W   <= 1'b0;
      pc_current_W <= '0;
      inst_W       <= '0;
      misalign_W   <= 1'b0;
    end else if (mem_stall) begin
      rd_W       <= '0;
      RegWrite_W <= 1'b0;
      misalign_W <= 1'b0;
    end else begin
      rd_data_W    <= MemToReg_M ? load_ext : ExeResult_M;
      rd_W         <= rd_M;
      RegWrite_W   <= RegWrite_M & ~trap;
      pc_current_W <= pc_current_M;
      inst_W       <= inst_M;
      misalign_W   <= trap;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset/abort sequence and
// randomized accesses checked against a behavioural model.
module tb_mem_access_stage;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] ExeResult_M, rs2_data_M, pc_current_M, inst_M;
  logic [4:0]  rd_M;
  logic [2:0]  StoreType_M, LoadType_M;
  logic        RegWrite_M, MemWrite_M, MemRead_M, MemToReg_M;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] rd_data_W, pc_current_W, inst_W;
  logic [4:0]  rd_W;
  logic        RegWrite_W, misalign_W;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .ExeResult_M(ExeResult_M), .rs2_data_M(rs2_data_M), .rd_M(rd_M),
    .pc_current_M(pc_current_M), .inst_M(inst_M),
    .StoreType_M(StoreType_M), .LoadType_M(LoadType_M),
    .RegWrite_M(RegWrite_M), .MemWrite_M(MemWrite_M), .MemRead_M(MemRead_M), .MemToReg_M(MemToReg_M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .rd_data_W(rd_data_W), .rd_W(rd_W), .RegWrite_W(RegWrite_W),
    .pc_current_W(pc_current_W), .inst_W(inst_W), .misalign_W(misalign_W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rdx, rw, m2r;
    logic [2:0]  lt, st;
    logic [31:0] addr, rs2, rdata, pc, inst;
    logic [4:0]  rd;
    int          gd, rvd;
  } acc_t;

  typedef struct {
    logic [31:0] rd_data, wdata;
    logic [3:0]  be;
    logic        rw, mis, req;
    int          stalls;
  } exp_t;

  typedef struct {
    acc_t a;
    exp_t e;
  } vec_t;

  int          total, passed;
  logic [31:0] last_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic acc_t mk_acc(logic wr, logic rdx, logic [2:0] lt, logic [2:0] st,
                                  logic [31:0] addr, logic [31:0] rs2, logic [31:0] rdata,
                                  logic [4:0] rd, logic rw, logic m2r, int gd, int rvd, int idx);
    acc_t a;
    a.wr = wr; a.rdx = rdx; a.lt = lt; a.st = st; a.addr = addr; a.rs2 = rs2; a.rdata = rdata;
    a.rd = rd; a.rw = rw; a.m2r = m2r; a.gd = gd; a.rvd = rvd;
    a.pc   = 32'h0000_1000 + 32'(idx) * 4;
    a.inst = 32'h0000_0013 + (32'(idx) << 7);
    return a;
  endfunction

  function automatic exp_t mk_exp(logic [31:0] rd_data, logic [3:0] be, logic [31:0] wdata,
                                  int stalls, logic rw, logic mis, logic req);
    exp_t e;
    e.rd_data = rd_data; e.be = be; e.wdata = wdata; e.stalls = stalls;
    e.rw = rw; e.mis = mis; e.req = req;
    return e;
  endfunction

  // Reference model: derived from the access rules with plain arithmetic
  function automatic exp_t model(acc_t a);
    exp_t        e;
    int          off;
    logic        iswr, isrd, mis, trap, go;
    logic [31:0] b, h, ld;
    off  = int'(a.addr % 4);
    iswr = a.wr;
    isrd = a.rdx && !a.wr;
    mis  = 1'b0;
    if (iswr)      mis = (a.st == 3'd1 && off % 2 == 1) || (a.st == 3'd2 && off != 0);
    else if (isrd) mis = ((a.lt == 3'd1 || a.lt == 3'd5) && off % 2 == 1) || (a.lt == 3'd2 && off != 0);
    trap = mis && TRAP;
    go   = (iswr || isrd) && !trap;
    b = (a.rdata >> (8 * off)) & 32'hFF;
    h = (a.rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (a.lt)
      3'd0:    ld = (b >= 128)   ? b - 256   : b;
      3'd1:    ld = (h >= 32768) ? h - 65536 : h;
      3'd4:    ld = b;
      3'd5:    ld = h;
      default: ld = a.rdata;
    endcase
    e.rd_data = a.m2r ? ld : a.addr;
    if (!iswr)             e.be = 4'h0;
    else if (a.st == 3'd0) e.be = 4'(1 << off);
    else if (a.st == 3'd1) e.be = (off >= 2) ? 4'hC : 4'h3;
    else                   e.be = 4'hF;
    if (a.st == 3'd0)      e.wdata = (a.rs2 & 32'hFF) * 32'h0101_0101;
    else if (a.st == 3'd1) e.wdata = (a.rs2 & 32'hFFFF) * 32'h0001_0001;
    else                   e.wdata = a.rs2;
    e.rw     = a.rw && !trap;
    e.mis    = trap;
    e.req    = go;
    e.stalls = !go ? 0 : (iswr ? a.gd : a.gd + a.rvd);
    return e;
  endfunction

  task automatic drive(input acc_t a);
    MemRead_M = a.rdx; MemWrite_M = a.wr; LoadType_M = a.lt; StoreType_M = a.st;
    ExeResult_M = a.addr; rs2_data_M = a.rs2; rd_M = a.rd; pc_current_M = a.pc; inst_M = a.inst;
    RegWrite_M = a.rw; MemToReg_M = a.m2r; dmem_rdata = a.rdata;
  endtask

  // Called just after a rising edge; returns just after the edge that retires the access.
  task automatic do_access(input string nm, input acc_t a, input exp_t e);
    int          n, reqs, stalls, bubbles;
    bit          done, st, got;
    logic [3:0]  be_s;
    logic [31:0] wd_s, ad_s;
    logic        we_s;
    n = 0; reqs = 0; stalls = 0; bubbles = 0; done = 0; got = 0;
    be_s = '0; wd_s = '0; ad_s = '0; we_s = 1'b0;
    drive(a);
    while (!done && n < 40) begin
      dmem_gnt    = (n == a.gd);
      dmem_rvalid = (n == a.gd + a.rvd) && a.rdx && !a.wr;
      #4;
      if (dmem_req) begin
        reqs++;
        if (!got) begin
          got = 1; be_s = dmem_be; wd_s = dmem_wdata; ad_s = dmem_addr; we_s = dmem_we;
        end
      end
      st = mem_stall;
      if (st) stalls++;
      else    done = 1;
      @(posedge clk); #1;
      if (st && !RegWrite_W && rd_W == 5'd0 && pc_current_W == last_pc) bubbles++;
      n++;
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL %s.timeout: stall still high after %0d cycles", nm, n);
    end
    chk({nm, ".req_cycles"}, reqs, e.req ? a.gd + 1 : 0);
    chk({nm, ".stall_cycles"}, stalls, e.stalls);
    chk({nm, ".bubbles"}, bubbles, e.stalls);
    if (e.req) begin
      chk({nm, ".addr"}, ad_s, a.addr & 32'hFFFF_FFFC);
      chk({nm, ".we"}, 32'(we_s), 32'(a.wr));
      chk({nm, ".be"}, 32'(be_s), 32'(e.be));
      if (a.wr) chk({nm, ".wdata"}, wd_s, e.wdata);
    end
    chk({nm, ".rd_data_W"}, rd_data_W, e.rd_data);
    chk({nm, ".RegWrite_W"}, 32'(RegWrite_W), 32'(e.rw));
    chk({nm, ".rd_W"}, 32'(rd_W), 32'(a.rd));
    chk({nm, ".misalign_W"}, 32'(misalign_W), 32'(e.mis));
    chk({nm, ".pc_W"}, pc_current_W, a.pc);
    chk({nm, ".inst_W"}, inst_W, a.inst);
    last_pc = a.pc;
  endtask

  localparam int NV = 8;
  vec_t vecs [NV];

  initial begin
    acc_t a;
    int   k;
    logic [2:0] lts [5];
    total = 0; passed = 0; last_pc = '0;
    lts[0] = 3'd0; lts[1] = 3'd1; lts[2] = 3'd2; lts[3] = 3'd4; lts[4] = 3'd5;

    //              wr   rdx  lt    st    addr          rs2           rdata         rd  rw   m2r gd rvd
    vecs[0].a = mk_acc(1'b1, 1'b0, 3'd2, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 0, 1, 0);
    vecs[0].e = mk_exp(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b1);
    vecs[1].a = mk_acc(1'b0, 1'b1, 3'd0, 3'd0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 5'd5, 1'b1, 1'b1, 0, 2, 1);
    vecs[1].e = mk_exp(32'hFFFF_FF80, 4'b0000, 32'h0, 2, 1'b1, 1'b0, 1'b1);
    vecs[2].a = mk_acc(1'b0, 1'b1, 3'd5, 3'd0, 32'h0000_0102, 32'h0, 32'h8001_1234, 5'd6, 1'b1, 1'b1, 0, 1, 2);
    vecs[2].e = mk_exp(32'h0000_8001, 4'b0000, 32'h0, 1, 1'b1, 1'b0, 1'b1);
    vecs[3].a = mk_acc(1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_0101, 32'h0000_00AB, 32'h0, 5'd0, 1'b0, 1'b0, 0, 1, 3);
    vecs[3].e = mk_exp(32'h0000_0101, 4'b0010, 32'hABAB_ABAB, 0, 1'b0, 1'b0, 1'b1);
    vecs[4].a = mk_acc(1'b1, 1'b0, 3'd0, 3'd1, 32'h0000_0102, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 1'b0, 3, 1, 4);
    vecs[4].e = mk_exp(32'h0000_0102, 4'b1100, 32'h5678_5678, 3, 1'b0, 1'b0, 1'b1);
    vecs[5].a = mk_acc(1'b0, 1'b1, 3'd2, 3'd0, 32'h0000_0102, 32'h0, 32'hCAFE_F00D, 5'd7, 1'b1, 1'b1, 1, 1, 5);
`ifdef MISALIGN_TRAP_EN
    vecs[5].e = mk_exp(32'hCAFE_F00D, 4'b0000, 32'h0, 0, 1'b0, 1'b1, 1'b0);
`else
    vecs[5].e = mk_exp(32'hCAFE_F00D, 4'b0000, 32'h0, 2, 1'b1, 1'b0, 1'b1);
`endif
    vecs[6].a = mk_acc(1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 5'd9, 1'b1, 1'b0, 0, 1, 6);
    vecs[6].e = mk_exp(32'h0000_1234, 4'b0000, 32'h0, 0, 1'b1, 1'b0, 1'b0);
    vecs[7].a = mk_acc(1'b0, 1'b1, 3'd1, 3'd0, 32'h0000_0100, 32'h0, 32'h0000_8000, 5'd10, 1'b1, 1'b1, 2, 3, 7);
    vecs[7].e = mk_exp(32'hFFFF_8000, 4'b0000, 32'h0, 5, 1'b1, 1'b0, 1'b1);

    // Reset with a load presented: no request may leak out
    rst = 1'b1; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    drive(vecs[1].a);
    @(posedge clk); #4;
    chk("reset.dmem_req", 32'(dmem_req), 32'd0);
    chk("reset.RegWrite_W", 32'(RegWrite_W), 32'd0);
    chk("reset.rd_data_W", rd_data_W, 32'd0);
    chk("reset.pc_W", pc_current_W, 32'd0);
    chk("reset.misalign_W", 32'(misalign_W), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) do_access($sformatf("vec%0d", i), vecs[i].a, vecs[i].e);

    // Reset while waiting for read data; a late rvalid must be ignored
    a = mk_acc(1'b0, 1'b1, 3'd2, 3'd0, 32'h0000_0200, 32'h0, 32'h1111_2222, 5'd11, 1'b1, 1'b1, 0, 1, 20);
    drive(a);
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort.dmem_req", 32'(dmem_req), 32'd0);
    chk("abort.RegWrite_W", 32'(RegWrite_W), 32'd0);
    chk("abort.rd_W", 32'(rd_W), 32'd0);
    chk("abort.rd_data_W", rd_data_W, 32'd0);
    chk("abort.pc_W", pc_current_W, 32'd0);
    chk("abort.inst_W", inst_W, 32'd0);
    a = mk_acc(1'b0, 1'b0, 3'd0, 3'd0, 32'h0000_0055, 32'h0, 32'h0BAD_0BAD, 5'd0, 1'b0, 1'b0, 0, 1, 21);
    drive(a);
    @(posedge clk); #1;
    rst = 1'b0;
    last_pc = '0;
    dmem_rvalid = 1'b1;
    #4;
    chk("abort.stray_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chk("abort.stray_rd_data", rd_data_W, 32'h0000_0055);
    last_pc = a.pc;
    a = mk_acc(1'b0, 1'b1, 3'd2, 3'd0, 32'h0000_0300, 32'h0, 32'h3333_4444, 5'd12, 1'b1, 1'b1, 1, 2, 22);
    do_access("abort.next_lw", a, model(a));

    // Randomized accesses against the model
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      a = mk_acc(1'b0, 1'b0, lts[$urandom_range(0, 4)], 3'($urandom_range(0, 2)), $urandom, $urandom,
                 $urandom, 5'($urandom_range(1, 31)), 1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(1, 3), 100 + i);
      if (k >= 2 && k <= 5) begin
        a.rdx = 1'b1; a.m2r = 1'b1;
      end else if (k >= 6) begin
        a.wr = 1'b1; a.rw = 1'b0;
        if (k == 9) a.rdx = 1'b1;
      end
      do_access($sformatf("rnd%0d", i), a, model(a));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
